i2c_responder: RTL and testbench
================================

I2C_RESPONDER -- requirements
Module: i2c_responder

Interface
REQ-001 Parameter DEVICE_ADDR, default 7'h39, is the 7-bit target address the block SHALL respond to.
REQ-002 Parameter REG_RESET, default 8'h00, is the value every register SHALL take on reset.
REQ-003 Clock  input  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 SCL  input  1  bus clock, asynchronous to Clock.
REQ-006 SDA_In  input  1  bus data as read from the pad, asynchronous.
REQ-007 SDA_Drive_Low  output  1  when 1, the pad SHALL pull SDA low; when 0, the pad SHALL release SDA.
REQ-008 Reg_Addr  input  8  local read-tap address.
REQ-009 Reg_RData  output  8  register[Reg_Addr], registered with one cycle of latency.
REQ-010 Write_Strobe  output  1  one-cycle pulse for each register written over the bus.
REQ-011 Write_Addr  output  8  address of the register written; valid while Write_Strobe=1.
REQ-012 Write_Data  output  8  data written; valid while Write_Strobe=1.
REQ-013 Busy  output  1  high from an addressed START until the next STOP, a non-matching address, or reset.

Function
REQ-014 SCL and SDA_In SHALL each pass through a 2-flop synchroniser; all decoding SHALL use the synchronised signals and their previous-cycle values.
REQ-015 START SHALL be detected when SDA falls while SCL=1; STOP SHALL be detected when SDA rises while SCL=1.
REQ-016 Data bits SHALL be sampled on synchronised SCL rising edges, MSB first; SDA_Drive_Low SHALL change only on synchronised SCL falling edges.
REQ-017 The state machine SHALL implement IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-018 START in any state, including a repeated START, SHALL enter ADDR with the bit count cleared.
REQ-019 STOP in any state SHALL enter IDLE, release SDA and clear Busy.
REQ-020 ADDR: after 8 bits, if bits[7:1]==DEVICE_ADDR the block SHALL go to ADDR_ACK and drive ACK low; otherwise it SHALL go to WAIT_STOP with SDA released.
REQ-021 ADDR_ACK: after the ACK clock, R/W=0 SHALL go to PTR if no pointer has been received since START, else to WDATA; R/W=1 SHALL go to RDATA, loading register[pointer].
REQ-022 PTR: the 8 received bits SHALL be loaded into the 8-bit pointer, the block SHALL ACK in PTR_ACK, then go to WDATA.
REQ-023 WDATA: after 8 bits the block SHALL write register[pointer], pulse Write_Strobe for exactly one Clock cycle in the cycle it enters WDATA_ACK, ACK, then increment the pointer.
REQ-024 RDATA: the block SHALL drive the inverse of each data bit onto SDA_Drive_Low, MSB first; in RDATA_ACK it SHALL release SDA and sample the master's ACK.
REQ-025 On master ACK=0 the pointer SHALL increment and the block SHALL return to RDATA with the next byte; on NACK=1 it SHALL enter WAIT_STOP.
REQ-026 The pointer SHALL wrap 8'hFF -> 8'h00 modulo 256 on increment.
REQ-027 The pointer SHALL persist across STOP so that a write-pointer/STOP/read sequence reads from that pointer.
REQ-028 If a bus write and a Reg_Addr read hit the same register in the same cycle, Reg_RData SHALL return the old value and show the new value one cycle later.
REQ-029 The block SHALL NOT stretch SCL.

Reset
REQ-030 During reset, state SHALL be IDLE, and SDA_Drive_Low, Busy, Write_Strobe, Write_Addr, Write_Data, pointer and Reg_RData SHALL all be 0.
REQ-031 During reset all 256 registers SHALL be set to REG_RESET.
REQ-032 Reset asserted mid-transaction SHALL release SDA on the next Clock edge; after reset the block SHALL ignore the bus until a new START.

Verification
REQ-033 START, 0x72, 0x10, 0xA5, STOP -> three ACKs; one Write_Strobe with Write_Addr=0x10, Write_Data=0xA5; Reg_Addr=0x10 yields 0xA5.
REQ-034 Write 0xFF: 0x11,0x22 -> Write_Strobes at 0xFF then 0x00 (wrap); registers hold 0x11 and 0x22.
REQ-035 START, 0x72, 0x10, repeated START, 0x73, read 2 bytes with ACK then NACK -> bytes returned equal register[0x10] and register[0x11]; SDA released after the NACK.
REQ-036 START, 0x74 -> no ACK, Busy=0, no Write_Strobe for any following bytes until STOP.
REQ-037 Reset asserted while driving a read bit of 0 -> SDA_Drive_Low=0 on the next edge; all registers read 0x00 afterwards.
REQ-038 STOP inserted mid-byte during WDATA -> no Write_Strobe, state IDLE, register unchanged.

Source files
------------

// File: rtl/i2c_responder.sv
// I2C target with a 256 x 8 register file: pointer byte, then sequential writes or reads.
// Bus inputs are 2-flop synchronised; SDA changes only on synchronised SCL falls and SCL is never stretched.
module i2c_responder #(
   parameter logic [6:0] DEVICE_ADDR = 7'h39,
   parameter logic [7:0] REG_RESET   = 8'h00
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_drive_low_o,
   input  logic [7:0] reg_addr_i,
   output logic [7:0] reg_rdata_o,
   output logic       write_strobe_o,
   output logic [7:0] write_addr_o,
   output logic [7:0] write_data_o,
   output logic       busy_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
   } state_t;

   state_t      state_q, state_d;
   logic        scl_meta_q, scl_sync_q, scl_prev_q;
   logic        sda_meta_q, sda_sync_q, sda_prev_q;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  ptr_q, ptr_d;
   logic        ptr_rcvd_q, ptr_rcvd_d;
   logic        mack_q, mack_d;
   logic        sda_low_q, sda_low_d;
   logic        busy_q, busy_d;
   logic        strobe_q, strobe_d;
   logic [7:0]  waddr_q, waddr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q;
   logic [7:0]  regs_q [256];

   logic        scl_rise, scl_fall, start_det, stop_det, byte_done, addr_match;
   logic [7:0]  ptr_inc;

   // Synchronisers run freely so the edge history is valid as soon as reset drops.
   always_ff @(posedge clk_i) begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
   end

   assign scl_rise   = scl_sync_q & ~scl_prev_q;
   assign scl_fall   = ~scl_sync_q & scl_prev_q;
   assign start_det  = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
   assign stop_det   = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
   assign byte_done  = (bit_cnt_q == 4'd8);
   assign addr_match = (shift_q[7:1] == DEVICE_ADDR);
   assign ptr_inc    = ptr_q + 8'd1;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (stop_det) begin
         state_d = S_IDLE;
      end else if (start_det) begin
         state_d = S_ADDR;
      end else if (scl_fall) begin
         unique case (state_q)
            S_ADDR:      if (byte_done) state_d = addr_match ? S_ADDR_ACK : S_WAIT_STOP;
            S_ADDR_ACK:  state_d = shift_q[0] ? S_RDATA : (ptr_rcvd_q ? S_WDATA : S_PTR);
            S_PTR:       if (byte_done) state_d = S_PTR_ACK;
            S_PTR_ACK:   state_d = S_WDATA;
            S_WDATA:     if (byte_done) state_d = S_WDATA_ACK;
            S_WDATA_ACK: state_d = S_WDATA;
            S_RDATA:     if (byte_done) state_d = S_RDATA_ACK;
            S_RDATA_ACK: state_d = mack_q ? S_WAIT_STOP : S_RDATA;
            default:     state_d = state_q;
         endcase
      end
   end

   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      ptr_d      = ptr_q;
      ptr_rcvd_d = ptr_rcvd_q;
      mack_d     = mack_q;
      sda_low_d  = sda_low_q;
      busy_d     = busy_q;
      strobe_d   = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      if (stop_det) begin
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
      end else if (start_det) begin
         bit_cnt_d  = 4'd0;
         sda_low_d  = 1'b0;
         ptr_rcvd_d = 1'b0;
      end else if (scl_rise) begin
         unique case (state_q)
            S_ADDR, S_PTR, S_WDATA: begin
               shift_d   = {shift_q[6:0], sda_sync_q};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
            S_RDATA:     bit_cnt_d = bit_cnt_q + 4'd1;
            S_RDATA_ACK: mack_d = sda_sync_q;
            default:     ;
         endcase
      end else if (scl_fall) begin
         unique case (state_q)
            S_ADDR: if (byte_done) begin
               sda_low_d = addr_match;
               busy_d    = addr_match;
            end
            S_ADDR_ACK: begin
               bit_cnt_d = 4'd0;
               if (shift_q[0]) begin
                  tx_d      = regs_q[ptr_q];
                  sda_low_d = ~regs_q[ptr_q][7];
               end else begin
                  sda_low_d = 1'b0;
               end
            end
            S_PTR: if (byte_done) begin
               ptr_d      = shift_q;
               ptr_rcvd_d = 1'b1;
               sda_low_d  = 1'b1;
            end
            S_WDATA: if (byte_done) begin
               sda_low_d = 1'b1;
               strobe_d  = 1'b1;
               waddr_d   = ptr_q;
               wdata_d   = shift_q;
            end
            S_PTR_ACK: begin
               bit_cnt_d = 4'd0;
               sda_low_d = 1'b0;
            end
            S_WDATA_ACK: begin
               bit_cnt_d = 4'd0;
               sda_low_d = 1'b0;
               ptr_d     = ptr_inc;
            end
            S_RDATA: begin
               if (byte_done) begin
                  sda_low_d = 1'b0;
               end else begin
                  tx_d      = {tx_q[6:0], 1'b0};
                  sda_low_d = ~tx_q[6];
               end
            end
            S_RDATA_ACK: begin
               if (mack_q) begin
                  sda_low_d = 1'b0;
               end else begin
                  bit_cnt_d = 4'd0;
                  ptr_d     = ptr_inc;
                  tx_d      = regs_q[ptr_inc];
                  sda_low_d = ~regs_q[ptr_inc][7];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         tx_q       <= 8'h00;
         ptr_q      <= 8'h00;
         ptr_rcvd_q <= 1'b0;
         mack_q     <= 1'b1;
         sda_low_q  <= 1'b0;
         busy_q     <= 1'b0;
         strobe_q   <= 1'b0;
         waddr_q    <= 8'h00;
         wdata_q    <= 8'h00;
         rdata_q    <= 8'h00;
         for (int i = 0; i < 256; i++) regs_q[i] <= REG_RESET;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ptr_q      <= ptr_d;
         ptr_rcvd_q <= ptr_rcvd_d;
         mack_q     <= mack_d;
         sda_low_q  <= sda_low_d;
         busy_q     <= busy_d;
         strobe_q   <= strobe_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         // Tap samples the array before this edge's write lands: old value now, new value next cycle.
         rdata_q    <= regs_q[reg_addr_i];
         if (strobe_d) regs_q[ptr_q] <= shift_q;
      end
   end

   assign sda_drive_low_o = sda_low_q;
   assign busy_o          = busy_q;
   assign write_strobe_o  = strobe_q;
   assign write_addr_o    = waddr_q;
   assign write_data_o    = wdata_q;
   assign reg_rdata_o     = rdata_q;

endmodule

// File: tb/tb_i2c_responder.sv
// Bench for i2c_responder: bit-banged I2C master, wired-AND SDA, register-file and pointer model.
module tb_i2c_responder;

   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       sda_drive_low;
   logic [7:0] reg_addr = 8'h00;
   logic [7:0] reg_rdata;
   logic       write_strobe;
   logic [7:0] write_addr, write_data;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   bit [7:0] m_regs [256];
   bit [7:0] m_ptr;

   logic [7:0] st_addr[$], st_data[$], st_rd_at[$], st_rd_after[$];
   bit         pend = 1'b0;

   assign sda_bus = sda_m & ~sda_drive_low;

   always #5 clk = ~clk;

   i2c_responder dut (
      .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda_bus),
      .sda_drive_low_o(sda_drive_low), .reg_addr_i(reg_addr), .reg_rdata_o(reg_rdata),
      .write_strobe_o(write_strobe), .write_addr_o(write_addr), .write_data_o(write_data),
      .busy_o(busy)
   );

   always @(negedge clk) begin
      if (pend) begin
         st_rd_after.push_back(reg_rdata);
         pend = 1'b0;
      end
      if (write_strobe) begin
         st_addr.push_back(write_addr);
         st_data.push_back(write_data);
         st_rd_at.push_back(reg_rdata);
         pend = 1'b1;
      end
   end

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic clear_strobes();
      st_addr.delete(); st_data.delete(); st_rd_at.delete(); st_rd_after.delete();
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q(); scl = 1'b1; wait_q();
      sda_m = 1'b0; wait_q(); scl = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q(); scl = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic i2c_write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; wait_q(); scl = 1'b1; wait_q(); scl = 1'b0; wait_q();
      end
      sda_m = 1'b1; wait_q(); scl = 1'b1; wait_q();
      ack = sda_bus;
      scl = 1'b0; wait_q();
   endtask

   task automatic i2c_read_byte(input logic nack, output logic [7:0] b);
      sda_m = 1'b1;
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         wait_q(); scl = 1'b1; wait_q();
         b = {b[6:0], sda_bus};
         scl = 1'b0;
      end
      sda_m = nack; wait_q(); scl = 1'b1; wait_q(); scl = 1'b0; wait_q();
      sda_m = 1'b1;
   endtask

   task automatic tap_read(input logic [7:0] a, output logic [7:0] v);
      reg_addr = a;
      @(negedge clk); @(negedge clk);
      v = reg_rdata;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      n_tests++; if (sda_drive_low !== 1'b0) begin n_fail++; $display("FAIL reset_sda got %b want 0", sda_drive_low); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_tests++; if ({write_strobe, write_addr, write_data} !== 17'h0) begin
         n_fail++; $display("FAIL reset_write got %b/%h/%h want 0/00/00", write_strobe, write_addr, write_data); end
      n_tests++; if (reg_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", reg_rdata); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      tap_read(8'h5A, v);
      n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg got %h want 00", v); end
      for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
      m_ptr = 8'h00;
   endtask

   task automatic test_basic_write();
      logic a0, a1, a2;
      logic [7:0] v, old;
      clear_strobes();
      old = m_regs[8'h10];
      reg_addr = 8'h10;
      i2c_start();
      i2c_write_byte(8'h72, a0);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
      i2c_write_byte(8'h10, a1);
      i2c_write_byte(8'hA5, a2);
      i2c_stop();
      repeat (4) @(negedge clk);
      m_regs[8'h10] = 8'hA5; m_ptr = 8'h11;
      n_tests++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL basic_acks got %b want 000", {a0, a1, a2}); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_stop got %b want 0", busy); end
      n_tests++;
      if (st_addr.size() != 1 || st_addr[0] !== 8'h10 || st_data[0] !== 8'hA5) begin
         n_fail++; $display("FAIL basic_strobe got %0d strobes first %h/%h want 1 at 10/a5",
                             st_addr.size(), st_addr.size() > 0 ? st_addr[0] : 8'hxx, st_data.size() > 0 ? st_data[0] : 8'hxx);
      end else begin
         n_tests++; if (st_rd_at[0] !== old || st_rd_after[0] !== 8'hA5) begin
            n_fail++; $display("FAIL tap_collision got %h then %h want %h then a5", st_rd_at[0], st_rd_after[0], old); end
      end
      tap_read(8'h10, v);
      n_tests++; if (v !== 8'hA5) begin n_fail++; $display("FAIL basic_tap got %h want a5", v); end
   endtask

   task automatic test_write_wrap();
      logic ack;
      logic [7:0] v;
      clear_strobes();
      i2c_start();
      i2c_write_byte(8'h72, ack); i2c_write_byte(8'hFF, ack);
      i2c_write_byte(8'h11, ack); i2c_write_byte(8'h22, ack);
      i2c_stop();
      repeat (4) @(negedge clk);
      m_regs[8'hFF] = 8'h11; m_regs[8'h00] = 8'h22; m_ptr = 8'h01;
      n_tests++;
      if (st_addr.size() != 2 || st_addr[0] !== 8'hFF || st_addr[1] !== 8'h00 ||
          st_data[0] !== 8'h11 || st_data[1] !== 8'h22) begin
         n_fail++; $display("FAIL wrap_strobes got %0d strobes want ff/11 then 00/22", st_addr.size());
      end
      tap_read(8'hFF, v);
      n_tests++; if (v !== 8'h11) begin n_fail++; $display("FAIL wrap_tap_ff got %h want 11", v); end
      tap_read(8'h00, v);
      n_tests++; if (v !== 8'h22) begin n_fail++; $display("FAIL wrap_tap_00 got %h want 22", v); end
   endtask

   task automatic test_random_write();
      logic ack;
      logic [7:0] p, d, v;
      int n;
      logic [7:0] ea[$], ed[$];
      for (int t = 0; t < 4; t++) begin
         clear_strobes(); ea.delete(); ed.delete();
         p = 8'($urandom);
         n = $urandom_range(1, 4);
         i2c_start();
         i2c_write_byte(8'h72, ack); i2c_write_byte(p, ack);
         for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            i2c_write_byte(d, ack);
            ea.push_back(p + 8'(i)); ed.push_back(d);
            m_regs[p + 8'(i)] = d;
         end
         i2c_stop();
         m_ptr = p + 8'(n);
         repeat (4) @(negedge clk);
         n_tests++;
         if (st_addr.size() != n) begin
            n_fail++; $display("FAIL rand_write_count got %0d want %0d", st_addr.size(), n);
         end else begin
            for (int i = 0; i < n; i++) begin
               n_tests++; if (st_addr[i] !== ea[i] || st_data[i] !== ed[i]) begin
                  n_fail++; $display("FAIL rand_write_strobe got %h/%h want %h/%h", st_addr[i], st_data[i], ea[i], ed[i]); end
            end
         end
         tap_read(p, v);
         n_tests++; if (v !== m_regs[p]) begin n_fail++; $display("FAIL rand_write_tap got %h want %h", v, m_regs[p]); end
      end
   endtask

   task automatic test_read_rstart();
      logic ack;
      logic [7:0] b0, b1;
      i2c_start();
      i2c_write_byte(8'h72, ack); i2c_write_byte(8'h10, ack);
      i2c_start();
      i2c_write_byte(8'h73, ack);
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rstart_addr_ack got %b want 0", ack); end
      i2c_read_byte(1'b0, b0);
      i2c_read_byte(1'b1, b1);
      n_tests++; if (sda_drive_low !== 1'b0) begin n_fail++; $display("FAIL nack_release got %b want 0", sda_drive_low); end
      i2c_stop();
      m_ptr = 8'h11;
      n_tests++; if (b0 !== m_regs[8'h10]) begin n_fail++; $display("FAIL rstart_byte0 got %h want %h", b0, m_regs[8'h10]); end
      n_tests++; if (b1 !== m_regs[8'h11]) begin n_fail++; $display("FAIL rstart_byte1 got %h want %h", b1, m_regs[8'h11]); end
   endtask

   task automatic test_random_read();
      logic ack;
      logic [7:0] p, b;
      int n;
      for (int t = 0; t < 3; t++) begin
         p = 8'($urandom);
         n = $urandom_range(1, 4);
         i2c_start(); i2c_write_byte(8'h72, ack); i2c_write_byte(p, ack); i2c_stop();
         i2c_start(); i2c_write_byte(8'h73, ack);
         for (int i = 0; i < n; i++) begin
            i2c_read_byte(i == n - 1, b);
            n_tests++; if (b !== m_regs[p + 8'(i)]) begin
               n_fail++; $display("FAIL rand_read got %h want %h at %h", b, m_regs[p + 8'(i)], p + 8'(i)); end
         end
         i2c_stop();
         m_ptr = p + 8'(n - 1);
      end
   endtask

   task automatic test_wrong_addr();
      logic a0, a1, a2;
      logic [7:0] v;
      clear_strobes();
      i2c_start();
      i2c_write_byte(8'h74, a0);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_busy got %b want 0", busy); end
      i2c_write_byte(m_ptr + 8'd3, a1);
      i2c_write_byte(8'($urandom), a2);
      i2c_stop();
      repeat (4) @(negedge clk);
      n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL wrong_acks got %b want 111", {a0, a1, a2}); end
      n_tests++; if (st_addr.size() != 0) begin n_fail++; $display("FAIL wrong_strobes got %0d want 0", st_addr.size()); end
      tap_read(m_ptr + 8'd3, v);
      n_tests++; if (v !== m_regs[m_ptr + 8'd3]) begin n_fail++; $display("FAIL wrong_tap got %h want %h", v, m_regs[m_ptr + 8'd3]); end
   endtask

   task automatic test_stop_mid_byte();
      logic ack;
      logic [7:0] p, v, old;
      clear_strobes();
      p = 8'($urandom);
      old = m_regs[p];
      i2c_start();
      i2c_write_byte(8'h72, ack); i2c_write_byte(p, ack);
      for (int i = 0; i < 4; i++) begin
         sda_m = ~old[7 - i]; wait_q(); scl = 1'b1; wait_q(); scl = 1'b0; wait_q();
      end
      i2c_stop();
      m_ptr = p;
      repeat (4) @(negedge clk);
      n_tests++; if (st_addr.size() != 0) begin n_fail++; $display("FAIL midstop_strobes got %0d want 0", st_addr.size()); end
      n_tests++; if (busy !== 1'b0 || sda_drive_low !== 1'b0) begin
         n_fail++; $display("FAIL midstop_idle got busy %b sda %b want 0 0", busy, sda_drive_low); end
      tap_read(p, v);
      n_tests++; if (v !== old) begin n_fail++; $display("FAIL midstop_tap got %h want %h", v, old); end
   endtask

   task automatic test_back_to_back();
      logic ack;
      logic [7:0] p1, p2, d1, d2;
      clear_strobes();
      p1 = 8'($urandom); p2 = p1 ^ 8'h5C; d1 = 8'($urandom); d2 = 8'($urandom);
      i2c_start(); i2c_write_byte(8'h72, ack); i2c_write_byte(p1, ack); i2c_write_byte(d1, ack);
      i2c_start(); i2c_write_byte(8'h72, ack); i2c_write_byte(p2, ack); i2c_write_byte(d2, ack);
      i2c_stop();
      m_regs[p1] = d1; m_regs[p2] = d2; m_ptr = p2 + 8'd1;
      repeat (4) @(negedge clk);
      n_tests++;
      if (st_addr.size() != 2 || st_addr[0] !== p1 || st_data[0] !== d1 || st_addr[1] !== p2 || st_data[1] !== d2) begin
         n_fail++; $display("FAIL b2b_strobes got %0d strobes want %h/%h then %h/%h", st_addr.size(), p1, d1, p2, d2);
      end
   endtask

   task automatic test_reset_mid_read();
      logic ack;
      logic [7:0] r, v;
      int bad;
      r = 8'h3C;
      i2c_start(); i2c_write_byte(8'h72, ack); i2c_write_byte(r, ack); i2c_write_byte(8'h35, ack); i2c_stop();
      i2c_start(); i2c_write_byte(8'h72, ack); i2c_write_byte(r, ack); i2c_stop();
      i2c_start(); i2c_write_byte(8'h73, ack);
      n_tests++; if (sda_drive_low !== 1'b1) begin n_fail++; $display("FAIL midread_drive got %b want 1", sda_drive_low); end
      rst = 1'b1;
      @(negedge clk);
      n_tests++; if (sda_drive_low !== 1'b0) begin n_fail++; $display("FAIL midread_release got %b want 0", sda_drive_low); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_q(); scl = 1'b1; wait_q();
      for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
      m_ptr = 8'h00;
      n_tests++; if (busy !== 1'b0 || sda_drive_low !== 1'b0) begin
         n_fail++; $display("FAIL postreset_idle got busy %b sda %b want 0 0", busy, sda_drive_low); end
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         tap_read(8'(i), v);
         if (v !== m_regs[i]) bad++;
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL postreset_regs got %0d nonzero want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_write_wrap();
      test_random_write();
      test_read_rstart();
      test_random_read();
      test_wrong_addr();
      test_stop_mid_byte();
      test_back_to_back();
      test_reset_mid_read();
      test_random_read();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
